// File: rtl/onehot_pkg.sv
// rtl/onehot_pkg.sv - shared sizes, FSM state type and one-hot helper for the round-robin arbiter
package onehot_pkg;

  localparam int N        = 8;
  localparam int SEL_W    = 3;
  localparam int CNT_W    = 4;
  localparam int MAX_HOLD = 15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [N-1:0] to_onehot(input logic [SEL_W-1:0] idx);
    return N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after rr_ptr
module rr_pick
  import onehot_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [N-1:0]     rot;
  logic [SEL_W-1:0] src;
  logic [SEL_W-1:0] off;

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    rot = '0;
    src = '0;
    off = '0;
    for (int i = 0; i < N; i++) begin
      src    = SEL_W'(i) + rr_ptr;
      rot[i] = req[src];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    win = rr_ptr + off;
    any = |req;
  end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// rtl/onehot_rr_arbiter.sv - round-robin arbiter with hold timeout and registered one-hot grant
module onehot_rr_arbiter
  import onehot_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] hold_cnt;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] win;
  logic             any;
  logic             owner_req;
  logic             hold_hit;
  logic             release_now;
  logic             timeout_d;

  rr_pick u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .win    (win),
    .any    (any)
  );

  // Release conditions for the current owner; done and req-drop mask the timeout flag.
  always_comb begin
    owner_req   = req[grant_idx];
    hold_hit    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    release_now = (state_q == BUSY) && (!owner_req || done || hold_hit);
    timeout_d   = (state_q == BUSY) && hold_hit && !done && owner_req;
  end

  // Next-state logic: IDLE always lasts at least one cycle, which gives the gap between owners.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = BUSY;
      BUSY:    if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Grant outputs, hold counter and rotation pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
    end else begin
      timeout <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any) begin
            grant       <= to_onehot(win);
            grant_idx   <= win;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= grant_idx + 1'b1;
            timeout     <= timeout_d;
          end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb/tb_onehot_rr_arbiter.sv - scoreboard bench for the round-robin one-hot arbiter
module tb_onehot_rr_arbiter;
  import onehot_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic             done = 1'b0;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  onehot_rr_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]     g;
    logic             v;
    logic [SEL_W-1:0] idx;
    logic             to;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_held  = 0;
  logic m_to    = 1'b0;

  int           wait_cnt[N];
  int           max_wait = 0;
  int           run_len  = 0;
  int           max_run  = 0;
  logic [N-1:0] prev_grant = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic d, input logic rs);
    int i;
    m_to = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (m_owner < 0 && r[i]) begin
          m_owner = i;
          m_held  = 1;
        end
      end
    end else begin
      if (!r[m_owner] || d || m_held == MAX_HOLD) begin
        m_to    = (m_held == MAX_HOLD) && !d && r[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic d, input logic rs);
    exp_t e;
    exp_t o;
    @(negedge clk);
    req  = r;
    done = d;
    rst  = rs;
    model_edge(r, d, rs);
    e.v   = (m_owner >= 0);
    e.g   = e.v ? (N'(1) << m_owner) : '0;
    e.idx = e.v ? SEL_W'(m_owner) : '0;
    e.to  = m_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    check("grant", grant, o.g);
    check("grant_valid", grant_valid, o.v);
    check("timeout", timeout, o.to);
    if (o.v) check("grant_idx", grant_idx, o.idx);
    check("onehot0", $onehot0(grant), 1);
    check("valid_is_or", grant_valid, |grant);
    for (int i = 0; i < N; i++) begin
      if (req[i] && !grant[i] && !rst) wait_cnt[i]++;
      else                             wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    if (grant != '0 && grant == prev_grant) run_len++;
    else if (grant != '0)                   run_len = 1;
    else                                    run_len = 0;
    if (run_len > max_run) max_run = run_len;
    prev_grant = grant;
  endtask

  initial begin
    int           cnt;
    logic [N-1:0] rv;
    logic         dv;
    logic         rsv;

    for (int i = 0; i < N; i++) wait_cnt[i] = 0;

    // Reset held with all requests active.
    step(8'hFF, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b1);
    check("rst_grant", grant, 8'h00);

    // Rotation 0,2,0 with done one cycle after each grant.
    step(8'h05, 1'b0, 1'b0);  check("t2_g0", grant, 8'h01);
    step(8'h05, 1'b1, 1'b0);  check("t2_gap0", grant, 8'h00);
    step(8'h05, 1'b0, 1'b0);  check("t2_g2", grant, 8'h04);
    step(8'h05, 1'b1, 1'b0);  check("t2_gap1", grant, 8'h00);
    step(8'h05, 1'b0, 1'b0);  check("t2_g0b", grant, 8'h01);
    step(8'h05, 1'b1, 1'b0);

    // Requester 7 alone, no done: 15 grant cycles then timeout, pointer wraps.
    cnt = 0;
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(8'h80, 1'b0, 1'b0);
      if (grant == 8'h80) cnt++;
    end
    check("t3_hold_cycles", cnt, MAX_HOLD);
    step(8'h80, 1'b0, 1'b0);
    check("t3_rel_grant", grant, 8'h00);
    check("t3_timeout", timeout, 1);
    step(8'h81, 1'b0, 1'b0);  check("t3_wrap", grant, 8'h01);
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // Owner 3: done on the last allowed cycle wins over the timeout.
    step(8'h08, 1'b0, 1'b0);  check("t4_g3", grant, 8'h08);
    for (int i = 0; i < MAX_HOLD - 1; i++) step(8'h08, 1'b0, 1'b0);
    check("t4_still", grant, 8'h08);
    step(8'h08, 1'b1, 1'b0);
    check("t4_rel", grant, 8'h00);
    check("t4_no_to", timeout, 0);
    step(8'h00, 1'b0, 1'b0);

    // Owner 5 interrupted by reset; pointer returns to 0.
    step(8'h20, 1'b0, 1'b0);  check("t5_g5", grant, 8'h20);
    step(8'h20, 1'b0, 1'b0);
    step(8'h21, 1'b0, 1'b1);
    check("t5_rst_grant", grant, 8'h00);
    check("t5_rst_to", timeout, 0);
    step(8'h21, 1'b0, 1'b0);  check("t5_g0", grant, 8'h01);
    step(8'h21, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // Random traffic.
    rv = '0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) rv = N'($urandom);
      dv  = ($urandom_range(0, 9) == 0);
      rsv = ($urandom_range(0, 999) == 0);
      step(rv, dv, rsv);
    end
    check("max_hold", max_run <= MAX_HOLD, 1);
    check("no_starve", max_wait <= N * (MAX_HOLD + 1), 1);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
